// File: rtl/rng_draw.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rng_draw: LFSR + rule-90/150 CA mixed RNG with warm-up and unbiased draws
// Revision 1.0
// ----------------------------------------------------------------------------
module rng_draw #(
  parameter  int OUT_W     = 32,
  parameter  int RANGE     = 7,
  parameter  int WARMUP    = 64,
  parameter  int MAX_TRIES = 16,
  localparam int IDX_W     = (RANGE > 2) ? $clog2(RANGE) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [31:0]       seed,
  input  logic              req,
  output logic              ready,
  output logic              valid,
  output logic [IDX_W-1:0]  rand_idx,
  output logic [OUT_W-1:0]  rand_raw,
  output logic              biased
);

  localparam logic [1:0] c_WARM = 2'd0;
  localparam logic [1:0] c_IDLE = 2'd1;
  localparam logic [1:0] c_DRAW = 2'd2;

  localparam int                TRY_W       = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0]  c_TRY_LAST  = TRY_W'(MAX_TRIES - 1);
  localparam logic [9:0]        c_WARM_LAST = (WARMUP > 0) ? 10'(WARMUP - 1) : 10'd0;
  localparam logic [IDX_W:0]    c_RANGE_EXT = (IDX_W + 1)'(RANGE);
  localparam logic [IDX_W-1:0]  c_RANGE     = IDX_W'(RANGE);
  // Galois taps of x^43+x^41+x^20+x+1 applied after the rotate (x^0 comes from the rotate)
  localparam logic [42:0]       c_LFSR_TAPS = 43'h200_0010_0002;
  localparam logic [36:0]       c_CASR_R150 = 37'h0_1000_0000;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [42:0]      r_lfsr;
  logic [42:0]      w_lfsr_nxt;
  logic [36:0]      r_casr;
  logic [36:0]      w_casr_nxt;
  logic [31:0]      w_seed_s;
  logic [31:0]      w_mix;
  logic [9:0]       r_warm;
  logic [TRY_W-1:0] r_try;
  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] r_idx;
  logic [OUT_W-1:0] r_raw;
  logic             r_valid;
  logic             r_biased;
  logic             w_in_range;
  logic             w_last_try;
  logic             w_warm_done;
  logic             w_ready;

  assign w_lfsr_nxt  = {r_lfsr[41:0], r_lfsr[42]} ^ (c_LFSR_TAPS & {43{r_lfsr[42]}});
  assign w_casr_nxt  = {r_casr[35:0], r_casr[36]} ^ {r_casr[0], r_casr[36:1]}
                     ^ (r_casr & c_CASR_R150);
  assign w_seed_s    = (seed == 32'd0) ? 32'd1 : seed;
  assign w_mix       = r_lfsr[31:0] ^ r_casr[31:0];
  assign w_cand      = w_mix[IDX_W-1:0];
  // Extra MSB so a power-of-two RANGE compares correctly
  assign w_in_range  = {1'b0, w_cand} < c_RANGE_EXT;
  assign w_last_try  = (r_try == c_TRY_LAST);
  assign w_warm_done = (WARMUP == 0) || (r_warm == c_WARM_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_WARM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      w_state_nxt = c_WARM;
    end else begin
      case (r_state)
        c_WARM:  if (w_warm_done) w_state_nxt = c_IDLE;
        c_IDLE:  if (req) w_state_nxt = c_DRAW;
        c_DRAW:  if (w_in_range || w_last_try) w_state_nxt = c_IDLE;
        default: w_state_nxt = c_WARM;
      endcase
    end
  end

  always_comb begin
    w_ready = (r_state == c_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= 43'd1;
      r_casr <= 37'd1;
    end else if (load) begin
      r_lfsr <= {11'd0, w_seed_s};
      r_casr <= {5'd0, w_seed_s};
    end else begin
      r_lfsr <= w_lfsr_nxt;
      r_casr <= w_casr_nxt;
    end
  end

  // Draw results hold across a load; only reset clears them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_warm   <= 10'd0;
      r_try    <= '0;
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_raw    <= '0;
      r_biased <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (load) begin
        r_warm <= 10'd0;
      end else begin
        case (r_state)
          c_WARM: r_warm <= r_warm + 10'd1;
          c_IDLE: if (req) r_try <= '0;
          c_DRAW: begin
            if (w_in_range || w_last_try) begin
              r_valid  <= 1'b1;
              r_idx    <= w_in_range ? w_cand : (w_cand - c_RANGE);
              r_raw    <= w_mix[OUT_W-1:0];
              r_biased <= !w_in_range;
            end else begin
              r_try <= r_try + TRY_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ready    = w_ready;
  assign valid    = r_valid;
  assign rand_idx = r_idx;
  assign rand_raw = r_raw;
  assign biased   = r_biased;

endmodule
`default_nettype wire

// File: tb/tb_rng_draw.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rng_draw: three rng_draw instances (RANGE 7/8/5) against a behavioural model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_rng_draw;

  localparam int P_RANGE [3] = '{7, 8, 5};
  localparam int P_TRIES [3] = '{16, 16, 1};
  localparam int P_WARM  [3] = '{64, 4, 0};

  logic             clk;
  logic             reset_n;
  logic             load;
  logic [31:0]      seed;
  logic [2:0]       r_req;
  logic [2:0]       w_ready;
  logic [2:0]       w_valid;
  logic [2:0]       w_biased;
  logic [2:0][2:0]  w_idx;
  logic [2:0][31:0] w_raw;

  int errors;
  int checks;

  // Reference generator state: what the DUT registers hold after the last edge
  logic [42:0] m_l;
  logic [36:0] m_c;

  rng_draw #(.OUT_W(32), .RANGE(7), .WARMUP(64), .MAX_TRIES(16)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .load(load), .seed(seed), .req(r_req[0]),
    .ready(w_ready[0]), .valid(w_valid[0]), .rand_idx(w_idx[0]),
    .rand_raw(w_raw[0]), .biased(w_biased[0])
  );

  rng_draw #(.OUT_W(32), .RANGE(8), .WARMUP(4), .MAX_TRIES(16)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .load(load), .seed(seed), .req(r_req[1]),
    .ready(w_ready[1]), .valid(w_valid[1]), .rand_idx(w_idx[1]),
    .rand_raw(w_raw[1]), .biased(w_biased[1])
  );

  rng_draw #(.OUT_W(32), .RANGE(5), .WARMUP(0), .MAX_TRIES(1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .load(load), .seed(seed), .req(r_req[2]),
    .ready(w_ready[2]), .valid(w_valid[2]), .rand_idx(w_idx[2]),
    .rand_raw(w_raw[2]), .biased(w_biased[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Polynomial view: multiply by x modulo x^43+x^41+x^20+x+1
  function automatic logic [42:0] lfsr_next(input logic [42:0] l);
    logic [42:0] r;
    r = l << 1;
    if (l[42]) r = r ^ 43'h200_0010_0003;
    return r;
  endfunction

  function automatic logic [36:0] casr_next(input logic [36:0] c);
    logic [36:0] n;
    for (int i = 0; i < 37; i++) begin
      n[i] = c[(i + 36) % 37] ^ c[(i + 1) % 37];
      if (i == 28) n[i] = n[i] ^ c[i];
    end
    return n;
  endfunction

  // Outcome of a draw accepted on the last edge; lat counts edges from acceptance.
  // All three instances have a 3-bit index, so candidates are mix mod 8.
  function automatic void predict(input logic [42:0] l0, input logic [36:0] c0,
                                  input int rng, input int tries,
                                  output int idx, output logic [31:0] raw,
                                  output bit b, output int lat);
    logic [42:0] l;
    logic [36:0] c;
    logic [31:0] mix;
    int cand;
    l = l0; c = c0;
    idx = 0; raw = '0; b = 1'b0; lat = 0;
    for (int t = 0; t < tries; t++) begin
      mix  = l[31:0] ^ c[31:0];
      cand = int'(mix % 32'd8);
      if (cand < rng) begin
        idx = cand; raw = mix; b = 1'b0; lat = t + 2;
        return;
      end
      if (t == tries - 1) begin
        idx = cand - rng; raw = mix; b = 1'b1; lat = t + 2;
        return;
      end
      l = lfsr_next(l);
      c = casr_next(c);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset_n) begin
      m_l = 43'd1;
      m_c = 37'd1;
    end else if (load) begin
      m_l = {11'd0, (seed == 32'd0) ? 32'd1 : seed};
      m_c = {5'd0, (seed == 32'd0) ? 32'd1 : seed};
    end else begin
      m_l = lfsr_next(m_l);
      m_c = casr_next(m_c);
    end
    @(negedge clk);
  endtask

  task automatic load_seed(input logic [31:0] s);
    load = 1'b1;
    seed = s;
    tick();
    load = 1'b0;
  endtask

  task automatic draw_check(input int d, input bit hold, output int o_idx,
                            output logic [31:0] o_raw, output bit o_b, output int o_lat);
    int n;
    int e_idx;
    int e_lat;
    logic [31:0] e_raw;
    bit e_b;
    bit got;
    o_idx = 0; o_raw = '0; o_b = 1'b0; o_lat = 0;
    n = 0;
    while (!w_ready[d] && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (w_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait dut%0d: ready=%b, expected 1 within 2000 cycles", d, w_ready[d]);
      return;
    end
    r_req[d] = 1'b1;
    tick();
    predict(m_l, m_c, P_RANGE[d], P_TRIES[d], e_idx, e_raw, e_b, e_lat);
    if (!hold) r_req[d] = 1'b0;
    n = 1;
    got = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      got = (w_valid[d] === 1'b1);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL valid_timeout dut%0d: no valid within %0d edges, expected at %0d", d, n, e_lat);
      return;
    end
    o_idx = int'(w_idx[d]);
    o_raw = w_raw[d];
    o_b   = w_biased[d];
    o_lat = n;
    checks++;
    if (n != e_lat) begin
      errors++;
      $display("FAIL draw_latency dut%0d: got %0d edges, expected %0d", d, n, e_lat);
    end
    checks++;
    if (o_idx != e_idx || o_raw !== e_raw || o_b !== e_b) begin
      errors++;
      $display("FAIL draw_result dut%0d: got idx=%0d raw=%h biased=%b, expected idx=%0d raw=%h biased=%b",
               d, o_idx, o_raw, o_b, e_idx, e_raw, e_b);
    end
    checks++;
    if (w_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL ready_with_valid dut%0d: ready=%b, expected 1", d, w_ready[d]);
    end
  endtask

  task automatic test_reset();
    bit exp_rdy;
    int first;
    reset_n = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({w_ready[d], w_valid[d], w_biased[d], w_idx[d], w_raw[d]} !== 38'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got rdy=%b vld=%b b=%b idx=%0d raw=%h, expected all 0",
                 d, w_ready[d], w_valid[d], w_biased[d], w_idx[d], w_raw[d]);
      end
    end
    reset_n = 1'b1;
    for (int n = 0; n < 70; n++) begin
      for (int d = 0; d < 3; d++) begin
        first   = (P_WARM[d] == 0) ? 1 : P_WARM[d];
        exp_rdy = (n >= first);
        checks++;
        if (w_ready[d] !== exp_rdy) begin
          errors++;
          $display("FAIL warmup_ready dut%0d cycle %0d: got %b, expected %b", d, n, w_ready[d], exp_rdy);
        end
        checks++;
        if ({w_valid[d], w_biased[d], w_idx[d], w_raw[d]} !== 37'd0) begin
          errors++;
          $display("FAIL warmup_outputs dut%0d cycle %0d: vld=%b b=%b idx=%0d raw=%h, expected all 0",
                   d, n, w_valid[d], w_biased[d], w_idx[d], w_raw[d]);
        end
      end
      tick();
    end
  endtask

  task automatic test_seed_zero();
    int gaps [100];
    int idx_a [100];
    logic [31:0] raw_a [100];
    int idx;
    int lat;
    logic [31:0] raw;
    bit b;
    for (int i = 0; i < 100; i++) gaps[i] = int'($urandom_range(0, 3));
    load_seed(32'd0);
    for (int i = 0; i < 100; i++) begin
      repeat (gaps[i]) tick();
      draw_check(0, 1'b0, idx, raw, b, lat);
      idx_a[i] = idx;
      raw_a[i] = raw;
    end
    load_seed(32'd1);
    for (int i = 0; i < 100; i++) begin
      repeat (gaps[i]) tick();
      draw_check(0, 1'b0, idx, raw, b, lat);
      checks++;
      if (idx != idx_a[i] || raw !== raw_a[i]) begin
        errors++;
        $display("FAIL seed_zero_seq draw %0d: seed1 idx=%0d raw=%h, seed0 idx=%0d raw=%h",
                 i, idx, raw, idx_a[i], raw_a[i]);
      end
    end
  endtask

  task automatic test_pow2_latency();
    int idx;
    int lat;
    logic [31:0] raw;
    bit b;
    load_seed($urandom);
    for (int i = 0; i < 50; i++) begin
      draw_check(1, 1'b1, idx, raw, b, lat);
      checks++;
      if (lat != 2 || b !== 1'b0) begin
        errors++;
        $display("FAIL pow2_latency draw %0d: got lat=%0d biased=%b, expected lat=2 biased=0", i, lat, b);
      end
    end
    r_req[1] = 1'b0;
  endtask

  task automatic test_fallback();
    int idx;
    int lat;
    int nb;
    logic [31:0] raw;
    bit b;
    nb = 0;
    load_seed($urandom);
    for (int i = 0; i < 100; i++) begin
      draw_check(2, 1'($urandom_range(0, 1)), idx, raw, b, lat);
      checks++;
      if (lat != 2) begin
        errors++;
        $display("FAIL fallback_latency draw %0d: got %0d, expected 2", i, lat);
      end
      if (b) nb++;
    end
    r_req[2] = 1'b0;
    checks++;
    if (nb == 0) begin
      errors++;
      $display("FAIL fallback_seen: got %0d biased draws of 100, expected at least 1", nb);
    end
  endtask

  task automatic test_load_mid_draw();
    int idx;
    int lat;
    logic [31:0] raw;
    bit b;
    logic [2:0] h_idx;
    logic [31:0] h_raw;
    logic h_b;
    load_seed($urandom);
    for (int i = 0; i < 3; i++) draw_check(0, 1'b0, idx, raw, b, lat);
    h_idx = w_idx[0];
    h_raw = w_raw[0];
    h_b   = w_biased[0];
    r_req[0] = 1'b1;
    tick();
    r_req[0] = 1'b0;
    load = 1'b1;
    seed = 32'hDEADBEEF;
    tick();
    load = 1'b0;
    for (int n = 0; n < 64; n++) begin
      checks++;
      if (w_ready[0] !== 1'b0 || w_valid[0] !== 1'b0) begin
        errors++;
        $display("FAIL load_warmup cycle %0d: rdy=%b vld=%b, expected 0 0", n, w_ready[0], w_valid[0]);
      end
      checks++;
      if (w_idx[0] !== h_idx || w_raw[0] !== h_raw || w_biased[0] !== h_b) begin
        errors++;
        $display("FAIL load_hold cycle %0d: idx=%0d raw=%h b=%b, expected idx=%0d raw=%h b=%b",
                 n, w_idx[0], w_raw[0], w_biased[0], h_idx, h_raw, h_b);
      end
      tick();
    end
    checks++;
    if (w_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL load_ready_after: got %b, expected 1", w_ready[0]);
    end
    for (int i = 0; i < 20; i++) draw_check(0, 1'b0, idx, raw, b, lat);
  endtask

  task automatic test_distribution();
    int cnt [7];
    int idx;
    int lat;
    logic [31:0] raw;
    bit b;
    for (int v = 0; v < 7; v++) cnt[v] = 0;
    load_seed(32'h1234_5678);
    for (int i = 0; i < 7000; i++) begin
      draw_check(0, 1'b1, idx, raw, b, lat);
      checks++;
      if (idx >= 7) begin
        errors++;
        $display("FAIL dist_range draw %0d: got idx=%0d, expected < 7", i, idx);
      end else begin
        cnt[idx]++;
      end
    end
    r_req[0] = 1'b0;
    for (int v = 0; v < 7; v++) begin
      checks++;
      if (cnt[v] < 850 || cnt[v] > 1150) begin
        errors++;
        $display("FAIL dist_count idx %0d: got %0d, expected 850..1150", v, cnt[v]);
      end
    end
  endtask

  task automatic test_reset_mid_draw();
    r_req[0] = 1'b1;
    tick();
    r_req[0] = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({w_ready[0], w_valid[0], w_biased[0], w_idx[0], w_raw[0]} !== 38'd0) begin
      errors++;
      $display("FAIL reset_mid_draw: rdy=%b vld=%b b=%b idx=%0d raw=%h, expected all 0",
               w_ready[0], w_valid[0], w_biased[0], w_idx[0], w_raw[0]);
    end
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (w_valid[0] !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_valid cycle %0d: got %b, expected 0", n, w_valid[0]);
      end
    end
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    load    = 1'b0;
    seed    = 32'd0;
    r_req   = 3'b000;
    m_l     = 43'd1;
    m_c     = 37'd1;
    @(negedge clk);
    test_reset();
    test_seed_zero();
    test_pow2_latency();
    test_fallback();
    test_load_mid_draw();
    test_distribution();
    test_reset_mid_draw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
